int_to_bcd: RTL and testbench

INT_TO_BCD -- requirements
Module: int_to_bcd

---
 rtl/int_to_bcd.sv | 168 ++++++++++++++++
 tb/tb_int_to_bcd.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_bcd.sv
// -----------------------------------------------------------------------------
// int_to_bcd
//
// Converts a 64-bit signed two's-complement integer into sign + magnitude BCD.
// The magnitude uses the iterative double-dabble algorithm, one bit per clock.
// Latency is fixed at 64 cycles from the input handshake to out_valid.
//
// Ports
//   clk        : single clock, rising-edge active
//   rst        : synchronous, active-high reset
//   in_valid   : int_in carries an operand this cycle
//   in_ready   : block is idle and will accept an operand
//   int_in     : 64-bit signed operand; only sampled on the handshake edge
//   out_valid  : bcd_out / neg_out / ndigits hold a finished result
//   out_ready  : consumer takes the result
//   bcd_out    : 19 BCD digits of |int_in|, digit k at [4k+3:4k], digit 0 = units
//   neg_out    : operand was negative
//   ndigits    : number of significant digits, 1..19 (1 for zero)
//
// FSM states
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for an operand; in_ready = 1; last result still shown
//   CONV  | 64 double-dabble iterations, one per cycle
//   DONE  | result presented with out_valid = 1 until out_ready
// -----------------------------------------------------------------------------
module int_to_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] int_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [75:0] bcd_out,
    output logic        neg_out,
    output logic [4:0]  ndigits
);

    localparam int NUM_DIGITS = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [63:0] mag;
    logic [75:0] bcd_acc;
    logic [5:0]  iter_cnt;
    logic        neg_acc;

    logic        accept;
    logic        last_iter;
    logic [75:0] bcd_adj;
    logic [75:0] bcd_shift;
    logic        bcd_carry_unused;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign last_iter = (state == CONV) && (iter_cnt == 6'd63);

    // -------------------------------------------------------------------------
    // Next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Double-dabble step: add 3 to every digit >= 5, then shift {bcd, mag}
    // left by one with the magnitude MSB entering digit 0.
    // -------------------------------------------------------------------------
    always_comb begin
        bcd_adj = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_acc[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_acc[4*k +: 4] + 4'd3;
            end else begin
                bcd_adj[4*k +: 4] = bcd_acc[4*k +: 4];
            end
        end
    end

    // The bit shifted out of digit 18 is always zero because |int_in| <= 2^63
    // fits in 19 digits; it is dropped.
    assign {bcd_carry_unused, bcd_shift} = {bcd_adj, mag[63]};

    // -------------------------------------------------------------------------
    // Datapath. The visible result registers are only loaded on the final
    // iteration, so the previous result stays on bcd_out while converting.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mag      <= '0;
            bcd_acc  <= '0;
            iter_cnt <= '0;
            neg_acc  <= 1'b0;
            bcd_out  <= '0;
            neg_out  <= 1'b0;
        end else if (accept) begin
            neg_acc  <= int_in[63];
            // -2^63 negates to itself, which is 2^63 read as unsigned.
            mag      <= int_in[63] ? (~int_in + 64'd1) : int_in;
            bcd_acc  <= '0;
            iter_cnt <= '0;
        end else if (state == CONV) begin
            mag      <= {mag[62:0], 1'b0};
            bcd_acc  <= bcd_shift;
            iter_cnt <= iter_cnt + 6'd1;
            if (last_iter) begin
                bcd_out <= bcd_shift;
                neg_out <= neg_acc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Significant digit count derived from the held result; zero reports 1.
    // -------------------------------------------------------------------------
    always_comb begin
        ndigits = 5'd1;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (bcd_out[4*k +: 4] != 4'd0) begin
                ndigits = 5'(k + 1);
            end
        end
    end

endmodule

// File: tb/tb_int_to_bcd.sv
module tb_int_to_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] int_in;
    logic        out_valid;
    logic        out_ready;
    logic [75:0] bcd_out;
    logic        neg_out;
    logic [4:0]  ndigits;

    int checks   = 0;
    int failures = 0;

    int_to_bcd dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .int_in    (int_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .neg_out   (neg_out),
        .ndigits   (ndigits)
    );

    always #5 clk = ~clk;

    // Directed operands with hand-written BCD expectations.
    logic [63:0] dir_in  [0:7] = '{64'h0000000000000001, 64'hFFFFFFFFFFFFFFFE,
                                   64'h0000000000000000, 64'h1000000000000000,
                                   64'hF000000000000000, 64'h8000000000000000,
                                   64'h7FFFFFFFFFFFFFFF, 64'd1234};
    logic [75:0] dir_bcd [0:7] = '{76'h1, 76'h2, 76'h0,
                                   76'h1152921504606846976, 76'h1152921504606846976,
                                   76'h9223372036854775808, 76'h9223372036854775807,
                                   76'h1234};
    logic        dir_neg [0:7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0]  dir_nd  [0:7] = '{5'd1, 5'd1, 5'd1, 5'd19, 5'd19, 5'd19, 5'd19, 5'd4};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: sign + magnitude, then decimal digits by repeated division.
    task automatic ref_model(input logic [63:0] x, output logic [75:0] bcd,
                             output logic neg, output logic [4:0] nd);
        logic [63:0] m;
        logic [63:0] d;
        neg = x[63];
        m   = neg ? (64'd0 - x) : x;
        bcd = '0;
        nd  = 5'd1;
        for (int k = 0; k < 19; k++) begin
            d = m % 64'd10;
            bcd[4*k +: 4] = d[3:0];
            if (d != 64'd0) nd = 5'(k + 1);
            m = m / 64'd10;
        end
    endtask

    // Drives one handshake and waits (bounded) for out_valid; cyc = cycles
    // from the handshake edge until out_valid was seen, 200 on timeout.
    task automatic do_convert(input logic [63:0] x, output int cyc);
        in_valid = 1'b1;
        int_in   = x;
        tick();
        in_valid = 1'b0;
        int_in   = {$urandom, $urandom};
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; int_in = '0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        checks++;
        if (bcd_out !== 76'h0 || neg_out !== 1'b0 || ndigits !== 5'd1) begin
            failures++;
            $display("FAIL reset_data: bcd=%h neg=%b nd=%0d want 0/0/1", bcd_out, neg_out, ndigits);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed;
        int cyc;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL dir%0d_ready: in_ready=%b want 1", i, in_ready);
            end
            do_convert(dir_in[i], cyc);
            checks++;
            if (cyc != 64) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d want 64", i, cyc);
            end
            checks++;
            if (bcd_out !== dir_bcd[i] || neg_out !== dir_neg[i] || ndigits !== dir_nd[i]) begin
                failures++;
                $display("FAIL dir%0d_result: in=%h bcd=%h neg=%b nd=%0d want bcd=%h neg=%b nd=%0d",
                         i, dir_in[i], bcd_out, neg_out, ndigits, dir_bcd[i], dir_neg[i], dir_nd[i]);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_busy: in_ready=%b want 0", i, in_ready);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== dir_bcd[i]) begin
                failures++;
                $display("FAIL dir%0d_release: in_ready=%b out_valid=%b bcd=%h want 1/0/%h",
                         i, in_ready, out_valid, bcd_out, dir_bcd[i]);
            end
        end
    endtask

    task automatic test_random;
        int          cyc;
        int          bad;
        logic [63:0] x;
        logic [75:0] eb;
        logic        en;
        logic [4:0]  ed;
        for (int i = 0; i < 24; i++) begin
            x = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) x = 64'd0 - x;
            ref_model(x, eb, en, ed);
            do_convert(x, cyc);
            checks++;
            if (cyc != 64) begin
                failures++;
                $display("FAIL rnd%0d_latency: got %0d want 64", i, cyc);
            end
            checks++;
            if (bcd_out !== eb || neg_out !== en || ndigits !== ed) begin
                failures++;
                $display("FAIL rnd%0d_result: in=%h bcd=%h neg=%b nd=%0d want bcd=%h neg=%b nd=%0d",
                         i, x, bcd_out, neg_out, ndigits, eb, en, ed);
            end
            bad = 0;
            for (int k = 0; k < 19; k++) if (bcd_out[4*k +: 4] > 4'd9) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL rnd%0d_digit_range: %0d digits above 9, want 0", i, bad);
            end
            repeat ($urandom_range(0, 3)) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        int          cyc;
        logic [63:0] x;
        logic [75:0] eb;
        logic        en;
        logic [4:0]  ed;
        x = {$urandom, $urandom};
        ref_model(x, eb, en, ed);
        do_convert(x, cyc);
        checks++;
        if (cyc != 64) begin
            failures++;
            $display("FAIL bp_latency: got %0d want 64", cyc);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            int_in   = {$urandom, $urandom};
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || bcd_out !== eb ||
                neg_out !== en || ndigits !== ed) begin
                failures++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b bcd=%h neg=%b nd=%0d want 1/0/%h/%b/%0d",
                         i, out_valid, in_ready, bcd_out, neg_out, ndigits, eb, en, ed);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== eb) begin
            failures++;
            $display("FAIL bp_release: ir=%b ov=%b bcd=%h want 1/0/%h", in_ready, out_valid, bcd_out, eb);
        end
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== eb || neg_out !== en) begin
            failures++;
            $display("FAIL bp_idle_hold: ir=%b ov=%b bcd=%h neg=%b want 1/0/%h/%b",
                     in_ready, out_valid, bcd_out, neg_out, eb, en);
        end
    endtask

    task automatic test_reset_abort;
        int cyc;
        int pulses;
        in_valid = 1'b1;
        int_in   = 64'h0123456789ABCDEF;
        tick();
        in_valid = 1'b0;
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== 76'h0 || ndigits !== 5'd1) begin
            failures++;
            $display("FAIL abort_state: ir=%b ov=%b bcd=%h nd=%0d want 1/0/0/1",
                     in_ready, out_valid, bcd_out, ndigits);
        end
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL abort_no_valid: saw %0d out_valid cycles want 0", pulses);
        end
        do_convert(64'd1234, cyc);
        checks++;
        if (cyc != 64 || bcd_out !== 76'h1234 || neg_out !== 1'b0 || ndigits !== 5'd4) begin
            failures++;
            $display("FAIL abort_next: lat=%0d bcd=%h neg=%b nd=%0d want 64/1234/0/4",
                     cyc, bcd_out, neg_out, ndigits);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_accept_after_reset;
        int cyc;
        rst      = 1'b1;
        in_valid = 1'b1;
        int_in   = 64'hFFFFFFFFFFFFFFFB;
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b0;
        int_in   = '0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 64 || bcd_out !== 76'h5 || neg_out !== 1'b1 || ndigits !== 5'd1) begin
            failures++;
            $display("FAIL post_reset_accept: lat=%0d bcd=%h neg=%b nd=%0d want 64/5/1/1",
                     cyc, bcd_out, neg_out, ndigits);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        test_accept_after_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
